// File: rtl/mul32_u_pkg.sv
// mul32_u_pkg: shared widths and FSM state type for the mul32_u sequential multiplier
package mul32_u_pkg;
   localparam int OP_W  = 32;
   localparam int RES_W = 64;
   localparam int CNT_W = $clog2(OP_W);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/mul32_u_step.sv
// mul32_u_step: one combinational radix-2 shift-add step
//   acc_i/acc_o       64-bit accumulator before/after the step
//   mcand_i/mcand_o   64-bit multiplicand, shifted left by one
//   mplier_i/mplier_o 32-bit multiplier, shifted right by one
module mul32_u_step
   import mul32_u_pkg::*;
(
   input  logic [RES_W-1:0] acc_i,
   input  logic [RES_W-1:0] mcand_i,
   input  logic [OP_W-1:0]  mplier_i,
   output logic [RES_W-1:0] acc_o,
   output logic [RES_W-1:0] mcand_o,
   output logic [OP_W-1:0]  mplier_o
);
   always_comb begin
      acc_o    = mplier_i[0] ? acc_i + mcand_i : acc_i;
      mcand_o  = mcand_i << 1;
      mplier_o = mplier_i >> 1;
   end
endmodule

// File: rtl/mul32_u.sv
// mul32_u: 32x32 -> 64 unsigned sequential shift-add multiplier, valid/ready handshake
//   clk, rst_n (async active-low)
//   in_valid/in_ready, op1, op2     operand handshake
//   out_valid/out_ready, res        product handshake; res holds the last product
//   busy                            high while computing or presenting a result
// Optional macro MUL32_U_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module mul32_u
   import mul32_u_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op1,
   input  logic [OP_W-1:0]  op2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] res,
   output logic             busy
);
   state_e           state_q;
   logic [RES_W-1:0] acc_q, mcand_q, res_q, acc_d, mcand_d;
   logic [OP_W-1:0]  mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q;
   logic             last;
   mul32_u_step u_step (
      .acc_i   (acc_q),
      .mcand_i (mcand_q),
      .mplier_i(mplier_q),
      .acc_o   (acc_d),
      .mcand_o (mcand_d),
      .mplier_o(mplier_d)
   );
`ifdef MUL32_U_EARLY_EXIT_EN
   // once no multiplier bits remain, further steps cannot change the accumulator
   assign last = (cnt_q == CNT_W'(OP_W - 1)) || (mplier_d == '0);
`else
   assign last = cnt_q == CNT_W'(OP_W - 1);
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         res_q    <= '0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               mcand_q  <= RES_W'(op1);
               mplier_q <= op2;
               acc_q    <= '0;
               cnt_q    <= '0;
               state_q  <= CALC;
            end
            CALC: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_d;
               mplier_q <= mplier_d;
               cnt_q    <= cnt_q + CNT_W'(1);
               // res only ever sees the finished product
               if (last) begin
                  res_q   <= acc_d;
                  state_q <= DONE;
               end
            end
            DONE: if (out_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign busy      = state_q != IDLE;
   assign res       = res_q;
endmodule

// File: tb/tb_mul32_u.sv
// tb_mul32_u: scoreboard bench for mul32_u with directed vectors
module tb_mul32_u;
   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] op1 = '0, op2 = '0;
   logic        in_ready, out_valid, busy;
   logic [63:0] res;
`ifdef MUL32_U_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif
   typedef struct {logic [63:0] r; int lat; int acc;} exp_t;
   exp_t q[$];
   int cyc = 0, checks = 0, errors = 0;
   bit prev_ov = 1'b0;
   mul32_u dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op1(op1), .op2(op2), .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .busy(busy)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask
   always @(negedge clk) begin : monitor
      exp_t e;
      if (out_valid && !prev_ov) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got out_valid with res %h, expected none", res);
         end else begin
            e = q.pop_front();
            chk("res", res, e.r);
            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
         end
      end
      prev_ov = out_valid;
   end
   // called at a negedge with the DUT idle; returns at the negedge after the handshake edge
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] ex,
                         input int le, input int hold);
      int n;
      logic [63:0] r0;
      chk("in_ready_idle", 64'(in_ready), 64'd1);
      in_valid  = 1'b1;
      op1       = a;
      op2       = b;
      out_ready = (hold == 0);
      q.push_back('{ex, EE ? le : 32, cyc + 1});
      @(negedge clk);
      in_valid = 1'b0;
      op1      = ~a;
      op2      = ~b;
      chk("busy_calc", 64'(busy), 64'd1);
      chk("in_ready_calc", 64'(in_ready), 64'd0);
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) begin
         checks++;
         errors++;
         $display("FAIL timeout: got no out_valid within 40 cycles, expected a result");
         return;
      end
      if (hold > 0) begin
         r0 = res;
         repeat (hold) begin
            in_valid = 1'b1;
            op1      = 32'hDEAD_BEEF;
            op2      = 32'h1234_5678;
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_res", res, r0);
            chk("in_ready_done", 64'(in_ready), 64'd0);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         @(negedge clk);
      end else begin
         @(negedge clk);
      end
      chk("handshake_valid", 64'(out_valid), 64'd0);
      chk("in_ready_after", 64'(in_ready), 64'd1);
      chk("res_kept", res, ex);
      out_ready = 1'b0;
   endtask
   initial begin
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_res", res, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(32'd9, 32'd7, 64'h3F, 3, 0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32, 0);
      run_op(32'h1234_5678, 32'd0, 64'd0, 1, 0);
      run_op(32'd0, 32'hFFFF_FFFF, 64'd0, 32, 0);
      run_op(32'h1234, 32'h100, 64'h12_3400, 9, 10);
      run_op(32'd3, 32'd5, 64'hF, 3, 0);
      run_op(32'h1_0000, 32'h1_0000, 64'h1_0000_0000, 17, 0);
      in_valid = 1'b1;
      op1      = 32'hFFFF;
      op2      = 32'hFFFF_FFFF;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (14) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_res", res, 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      chk("midrst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("post_rst_out_valid", 64'(out_valid), 64'd0);
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL global_timeout: got no completion, expected finish before 200000");
      $fatal(1);
   end
endmodule
